// File: rtl/change_trig_pkg.sv
// Shared types and sizing helpers for the increment-on-change loop.
package change_trig_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    SETTLED  = 2'd2,
    LOOP_ERR = 2'd3
  } state_e;

  // Bits needed to hold 0..max_iters inclusive.
  function automatic int iter_w_f(input int max_iters);
    int w;
    w = 1;
    while ((2 ** w) < (max_iters + 1)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/change_trig_incr_loop_bit_change_detect.sv
// Tracks the last sampled value of the watched bit and flags a difference.
module bit_change_detect (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic load_en,
  input  logic cur_bit,
  input  logic old_bit,
  output logic chg
);

  logic prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    // A load captures the bit as it was before the new value lands.
    if (load_en)        prev_d = old_bit;
    else if (sample_en) prev_d = cur_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign chg = cur_bit ^ prev_q;

endmodule

// File: rtl/change_trig_incr_loop.sv
// Register that increments while its watched bit keeps changing, with an
// iteration bound that flags a non-settling loop instead of spinning.
module change_trig_incr_loop
  import change_trig_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int WATCH_BIT = 0,
  parameter int MAX_ITERS = 8,
  parameter int ITER_W    = iter_w_f(MAX_ITERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  output logic [WIDTH-1:0]  x,
  output logic              busy,
  output logic              done,
  output logic              loop_err,
  output logic [ITER_W-1:0] iter_count
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              chg, load_acc, at_max, inc_en;

  assign load_acc = load_valid && (state_q != EVAL);
  assign at_max   = (iter_q == ITER_W'(MAX_ITERS));
  assign inc_en   = (state_q == EVAL) && chg && !at_max;

  bit_change_detect u_det (
    .clk       (clk),
    .rst       (rst),
    .sample_en (inc_en),
    .load_en   (load_acc),
    .cur_bit   (x_q[WATCH_BIT]),
    .old_bit   (x_q[WATCH_BIT]),
    .chg       (chg)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    iter_d  = iter_q;
    if (load_acc) begin
      x_d     = load_data;
      iter_d  = '0;
      state_d = EVAL;
    end else if (state_q == EVAL) begin
      if (!chg) begin
        state_d = SETTLED;
      end else if (at_max) begin
        state_d = LOOP_ERR;
      end else begin
        // Wrap from all-ones to zero is intentional and re-evaluated.
        x_d    = x_q + WIDTH'(1);
        iter_d = iter_q + ITER_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      iter_q  <= iter_d;
    end
  end

  assign load_ready = (state_q != EVAL);
  assign busy       = (state_q == EVAL);
  assign done       = (state_q == SETTLED);
  assign loop_err   = (state_q == LOOP_ERR);
  assign x          = x_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_change_trig_incr_loop.sv
// Directed bench for change_trig_incr_loop across three parameterisations.
module tb_change_trig_incr_loop;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // dut0: WIDTH=16 WATCH_BIT=0
  logic        lv0 = 1'b0;
  logic [15:0] ld0 = '0;
  logic        rdy0, busy0, done0, err0;
  logic [15:0] x0;
  logic [3:0]  it0;
  // dut1: WIDTH=16 WATCH_BIT=1
  logic        lv1 = 1'b0;
  logic [15:0] ld1 = '0;
  logic        rdy1, busy1, done1, err1;
  logic [15:0] x1;
  logic [3:0]  it1;
  // dut2: WIDTH=4 WATCH_BIT=3
  logic        lv2 = 1'b0;
  logic [3:0]  ld2 = '0;
  logic        rdy2, busy2, done2, err2;
  logic [3:0]  x2;
  logic [3:0]  it2;

  change_trig_incr_loop #(.WIDTH(16), .WATCH_BIT(0), .MAX_ITERS(8)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv0), .load_data(ld0), .load_ready(rdy0),
    .x(x0), .busy(busy0), .done(done0), .loop_err(err0), .iter_count(it0));
  change_trig_incr_loop #(.WIDTH(16), .WATCH_BIT(1), .MAX_ITERS(8)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv1), .load_data(ld1), .load_ready(rdy1),
    .x(x1), .busy(busy1), .done(done1), .loop_err(err1), .iter_count(it1));
  change_trig_incr_loop #(.WIDTH(4), .WATCH_BIT(3), .MAX_ITERS(8)) dut2 (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2), .load_ready(rdy2),
    .x(x2), .busy(busy2), .done(done2), .loop_err(err2), .iter_count(it2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({x0, it0, busy0, done0, err0, rdy0} !== {16'h0, 4'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_dut0 got x=%h it=%0d b/d/e/r=%b%b%b%b want x=0 it=0 b/d/e/r=0001",
                         x0, it0, busy0, done0, err0, rdy0);
    end
    checks++;
    if ({x1, it1, busy1, done1, err1, rdy1} !== {16'h0, 4'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_dut1 got x=%h it=%0d b/d/e/r=%b%b%b%b want 0/0/0001",
                         x1, it1, busy1, done1, err1, rdy1);
    end
    checks++;
    if ({x2, it2, busy2, done2, err2, rdy2} !== {4'h0, 4'h0, 4'b0001}) begin
      errors++; $display("FAIL reset_dut2 got x=%h it=%0d b/d/e/r=%b%b%b%b want 0/0/0001",
                         x2, it2, busy2, done2, err2, rdy2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_no_change();
    do_reset();
    lv0 = 1'b1; ld0 = 16'h0002;
    tick();
    lv0 = 1'b0;
    checks++;
    if ({busy0, done0, rdy0} !== 3'b100) begin
      errors++; $display("FAIL nochg_accept got b/d/r=%b%b%b want 100", busy0, done0, rdy0);
    end
    tick();
    checks++;
    if ({x0, it0, done0, err0, busy0} !== {16'h0002, 4'd0, 3'b100}) begin
      errors++; $display("FAIL nochg_settle got x=%h it=%0d d/e/b=%b%b%b want x=0002 it=0 d/e/b=100",
                         x0, it0, done0, err0, busy0);
    end
  endtask

  task automatic test_watch_bit1();
    do_reset();
    lv1 = 1'b1; ld1 = 16'h0002;
    tick();
    lv1 = 1'b0;
    tick();
    checks++;
    if ({x1, it1, busy1} !== {16'h0003, 4'd1, 1'b1}) begin
      errors++; $display("FAIL wb1_incr got x=%h it=%0d b=%b want x=0003 it=1 b=1", x1, it1, busy1);
    end
    tick();
    checks++;
    if ({x1, it1, done1, err1} !== {16'h0003, 4'd1, 2'b10}) begin
      errors++; $display("FAIL wb1_settle got x=%h it=%0d d/e=%b%b want x=0003 it=1 d/e=10",
                         x1, it1, done1, err1);
    end
  endtask

  task automatic test_back_to_back();
    // dut1 is SETTLED at x=3; reload while done is high.
    lv1 = 1'b1; ld1 = 16'h0005;
    tick();
    lv1 = 1'b0;
    checks++;
    if ({done1, busy1, x1, it1} !== {2'b01, 16'h0005, 4'd0}) begin
      errors++; $display("FAIL b2b_accept got d/b=%b%b x=%h it=%0d want d/b=01 x=0005 it=0",
                         done1, busy1, x1, it1);
    end
    repeat (3) tick();
    checks++;
    if ({x1, it1, done1, err1, busy1} !== {16'h0007, 4'd2, 3'b100}) begin
      errors++; $display("FAIL b2b_settle got x=%h it=%0d d/e/b=%b%b%b want x=0007 it=2 d/e/b=100",
                         x1, it1, done1, err1, busy1);
    end
  endtask

  task automatic test_loop_err();
    int n;
    do_reset();
    lv0 = 1'b1; ld0 = 16'h0001;
    tick();
    lv0 = 1'b0;
    n = 0;
    while (busy0 && n < 30) begin tick(); n++; end
    checks++;
    if (n != 9) begin
      errors++; $display("FAIL loop_cycles got %0d want 9", n);
    end
    checks++;
    if ({x0, it0, err0, done0, rdy0} !== {16'h0009, 4'd8, 3'b101}) begin
      errors++; $display("FAIL loop_state got x=%h it=%0d e/d/r=%b%b%b want x=0009 it=8 e/d/r=101",
                         x0, it0, err0, done0, rdy0);
    end
    tick();
    checks++;
    if ({x0, it0, err0} !== {16'h0009, 4'd8, 1'b1}) begin
      errors++; $display("FAIL loop_hold got x=%h it=%0d e=%b want x=0009 it=8 e=1", x0, it0, err0);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    lv2 = 1'b1; ld2 = 4'hF;
    tick();
    lv2 = 1'b0;
    tick();
    checks++;
    if ({x2, it2, busy2} !== {4'h0, 4'd1, 1'b1}) begin
      errors++; $display("FAIL wrap_zero got x=%h it=%0d b=%b want x=0 it=1 b=1", x2, it2, busy2);
    end
    n = 0;
    while (busy2 && n < 20) begin tick(); n++; end
    checks++;
    if ({x2, it2, done2, err2, n[3:0]} !== {4'h1, 4'd2, 2'b10, 4'd2}) begin
      errors++; $display("FAIL wrap_settle got x=%h it=%0d d/e=%b%b cyc=%0d want x=1 it=2 d/e=10 cyc=2",
                         x2, it2, done2, err2, n);
    end
  endtask

  task automatic test_ignore_and_abort();
    int n;
    do_reset();
    lv0 = 1'b1; ld0 = 16'h0001;
    tick();
    ld0 = 16'h0100;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++; $display("FAIL ign_ready got %b want 0", rdy0);
    end
    tick();
    lv0 = 1'b0;
    n = 0;
    while (busy0 && n < 30) begin tick(); n++; end
    checks++;
    if ({x0, it0, err0} !== {16'h0009, 4'd8, 1'b1}) begin
      errors++; $display("FAIL ign_final got x=%h it=%0d e=%b want x=0009 it=8 e=1", x0, it0, err0);
    end
    // Load 0 from x=9: bit 0 goes 1->0 so evaluation starts incrementing.
    lv0 = 1'b1; ld0 = 16'h0000;
    tick();
    lv0 = 1'b0;
    tick();
    checks++;
    if ({x0, it0, busy0} !== {16'h0001, 4'd1, 1'b1}) begin
      errors++; $display("FAIL abort_pre got x=%h it=%0d b=%b want x=0001 it=1 b=1", x0, it0, busy0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({x0, it0, busy0, done0, err0, rdy0} !== {16'h0, 4'd0, 4'b0001}) begin
      errors++; $display("FAIL abort_async got x=%h it=%0d b/d/e/r=%b%b%b%b want 0/0/0001",
                         x0, it0, busy0, done0, err0, rdy0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if ({x0, busy0, done0, err0} !== {16'h0, 3'b000}) begin
      errors++; $display("FAIL abort_after got x=%h b/d/e=%b%b%b want 0/000", x0, busy0, done0, err0);
    end
  endtask

  initial begin
    test_reset();
    test_no_change();
    test_watch_bit1();
    test_back_to_back();
    test_loop_err();
    test_wrap();
    test_ignore_and_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
